// File: rtl/vga_pkg.sv
// Shared timing defaults, cell codes and colour table for the tile renderer.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 29;
  localparam int GRID_COLS_DEF = 10;
  localparam int GRID_ROWS_DEF = 10;
  localparam int TILE_W_DEF    = 64;
  localparam int TILE_H_DEF    = 48;

  typedef enum logic [2:0] {
    BG, WALL, P1, P2, BOMB_NEW, BOMB_AGE, EXPLODE, RSVD
  } cell_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK   = rgb_t'(8'b000_000_00);
  localparam rgb_t BANNER_P1   = rgb_t'(8'b110_000_00);
  localparam rgb_t BANNER_P2   = rgb_t'(8'b000_000_11);
  localparam rgb_t BANNER_DRAW = rgb_t'(8'b010_010_01);

  function automatic rgb_t palette(cell_e code);
    palette = RGB_BLACK;
    case (code)
      BG:       palette = rgb_t'(8'b111_111_11);
      WALL:     palette = rgb_t'(8'b011_011_01);
      P1:       palette = rgb_t'(8'b111_000_00);
      P2:       palette = rgb_t'(8'b000_000_11);
      BOMB_NEW: palette = rgb_t'(8'b000_000_00);
      BOMB_AGE: palette = rgb_t'(8'b100_000_00);
      EXPLODE:  palette = rgb_t'(8'b111_110_00);
      RSVD:     palette = rgb_t'(8'b111_000_11);
    endcase
  endfunction
endpackage

// File: rtl/vga_tile_renderer_if.sv
// Game-state inputs and VGA pin outputs of the tile renderer.
interface vga_tile_renderer_if #(
  parameter int N_CELLS = 100
);
  logic [3*N_CELLS-1:0] tile_map;
  logic [1:0]           game_over;
  logic                 hsync;
  logic                 vsync;
  logic [2:0]           red;
  logic [2:0]           green;
  logic [1:0]           blue;
  logic                 frame_start;

  modport master (output tile_map, game_over,
                  input  hsync, vsync, red, green, blue, frame_start);
  modport slave  (input  tile_map, game_over,
                  output hsync, vsync, red, green, blue, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters: raw syncs, active flag, frame start and wrap strobes.
module vga_timing_gen import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic pixel_clk,
  input  logic rst,
  output logic h_last_o,
  output logic v_last_o,
  output logic active_o,
  output logic hsync_raw_o,
  output logic vsync_raw_o,
  output logic frame_start_raw_o,
  output logic snap_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW = $clog2(H_TOTAL);
  localparam int VCW = $clog2(V_TOTAL);

  logic [HCW-1:0] hc_q, hc_d;
  logic [VCW-1:0] vc_q, vc_d;

  assign h_last_o          = (hc_q == HCW'(H_TOTAL-1));
  assign v_last_o          = (vc_q == VCW'(V_TOTAL-1));
  assign active_o          = (hc_q < HCW'(H_ACTIVE)) && (vc_q < VCW'(V_ACTIVE));
  assign hsync_raw_o       = !((hc_q >= HCW'(H_ACTIVE+H_FP)) && (hc_q < HCW'(H_ACTIVE+H_FP+H_SYNC)));
  assign vsync_raw_o       = !((vc_q >= VCW'(V_ACTIVE+V_FP)) && (vc_q < VCW'(V_ACTIVE+V_FP+V_SYNC)));
  assign frame_start_raw_o = (hc_q == '0) && (vc_q == '0);
  assign snap_o            = (hc_q == '0) && (vc_q == VCW'(V_ACTIVE));

  // Next raster position: vc steps only on hc wrap.
  always_comb begin
    hc_d = hc_q + HCW'(1);
    vc_d = vc_q;
    if (h_last_o) begin
      hc_d = '0;
      vc_d = v_last_o ? '0 : vc_q + VCW'(1);
    end
  end

  // Raster position register.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end
endmodule

// File: rtl/vga_tile_renderer.sv
// Tile-map VGA renderer: tile tracking, per-frame snapshot, 2-stage output pipe.
module vga_tile_renderer import vga_pkg::*; #(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int GRID_COLS = GRID_COLS_DEF,
  parameter int GRID_ROWS = GRID_ROWS_DEF,
  parameter int TILE_W    = TILE_W_DEF,
  parameter int TILE_H    = TILE_H_DEF
) (
  input logic pixel_clk,
  input logic rst,
  vga_tile_renderer_if.slave bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int N_CELLS = GRID_COLS * GRID_ROWS;
  localparam int PXW = $clog2(TILE_W + 1);
  localparam int PYW = $clog2(TILE_H + 1);
  localparam int TXW = $clog2(H_TOTAL + 1);
  localparam int TYW = $clog2(V_TOTAL + 1);

  logic h_last, v_last, active, hs_raw, vs_raw, fs_raw, snap;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .pixel_clk         (pixel_clk),
    .rst               (rst),
    .h_last_o          (h_last),
    .v_last_o          (v_last),
    .active_o          (active),
    .hsync_raw_o       (hs_raw),
    .vsync_raw_o       (vs_raw),
    .frame_start_raw_o (fs_raw),
    .snap_o            (snap)
  );

  logic [PXW-1:0]       px_q, px_d;
  logic [PYW-1:0]       py_q, py_d;
  logic [TXW-1:0]       tx_q, tx_d;
  logic [TYW-1:0]       ty_q, ty_d;
  logic [3*N_CELLS-1:0] shadow_map_q, shadow_map_d;
  logic [1:0]           shadow_go_q, shadow_go_d;

  // Tile coordinates track hc/vc incrementally, so no divider is needed.
  always_comb begin
    px_d = px_q;
    tx_d = tx_q;
    py_d = py_q;
    ty_d = ty_q;
    if (h_last) begin
      px_d = '0;
      tx_d = '0;
      if (v_last) begin
        py_d = '0;
        ty_d = '0;
      end else if (py_q == PYW'(TILE_H-1)) begin
        py_d = '0;
        ty_d = ty_q + TYW'(1);
      end else begin
        py_d = py_q + PYW'(1);
      end
    end else if (px_q == PXW'(TILE_W-1)) begin
      px_d = '0;
      tx_d = tx_q + TXW'(1);
    end else begin
      px_d = px_q + PXW'(1);
    end
  end

  // Map and game state are captured once per frame, on the first blank line.
  always_comb begin
    shadow_map_d = shadow_map_q;
    shadow_go_d  = shadow_go_q;
    if (snap) begin
      shadow_map_d = bus.tile_map;
      shadow_go_d  = bus.game_over;
    end
  end

  // Tile counters and snapshot registers.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      px_q <= '0;
      py_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      shadow_map_q <= '0;
      shadow_go_q  <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
      shadow_map_q <= shadow_map_d;
      shadow_go_q  <= shadow_go_d;
    end
  end

  logic  in_grid;
  int    cell_idx;
  cell_e code_d;

  // Cell lookup; outside the grid the index is unused.
  always_comb begin
    in_grid  = (tx_q < TXW'(GRID_COLS)) && (ty_q < TYW'(GRID_ROWS));
    cell_idx = int'(ty_q) * GRID_COLS + int'(tx_q);
    code_d   = BG;
    if (in_grid) code_d = cell_e'(shadow_map_q[3*cell_idx +: 3]);
  end

  cell_e      code1_q;
  logic       act1_q, grid1_q, hs1_q, vs1_q, fs1_q;
  logic [1:0] go1_q;

  // Stage 1: cell code, flags and raw syncs.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      code1_q <= BG;
      act1_q  <= 1'b0;
      grid1_q <= 1'b0;
      go1_q   <= '0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      fs1_q   <= 1'b0;
    end else begin
      code1_q <= code_d;
      act1_q  <= active;
      grid1_q <= in_grid;
      go1_q   <= shadow_go_q;
      hs1_q   <= hs_raw;
      vs1_q   <= vs_raw;
      fs1_q   <= fs_raw;
    end
  end

  rgb_t rgb_d, rgb_q;
  logic hs2_q, vs2_q, fs2_q;

  // Colour priority: blanking, game-over banner, off-grid, palette.
  always_comb begin
    rgb_d = RGB_BLACK;
    if (act1_q) begin
      case (go1_q)
        2'd1:    rgb_d = BANNER_P1;
        2'd2:    rgb_d = BANNER_P2;
        2'd3:    rgb_d = BANNER_DRAW;
        default: rgb_d = grid1_q ? palette(code1_q) : RGB_BLACK;
      endcase
    end
  end

  // Stage 2: pin registers, syncs kept aligned with colour.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      rgb_q <= RGB_BLACK;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
      fs2_q <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      fs2_q <= fs1_q;
    end
  end

  assign bus.red         = rgb_q.r;
  assign bus.green       = rgb_q.g;
  assign bus.blue        = rgb_q.b;
  assign bus.hsync       = hs2_q;
  assign bus.vsync       = vs2_q;
  assign bus.frame_start = fs2_q;
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench: two shrunk-timing renderers (10 and 8 columns) plus one at default
// timing, all compared every cycle against an arithmetic raster model.
module tb_vga_tile_renderer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [299:0] map_v;
  logic [1:0]   go_v;

  vga_tile_renderer_if #(.N_CELLS(100)) if_a();
  vga_tile_renderer_if #(.N_CELLS(80))  if_b();
  vga_tile_renderer_if #(.N_CELLS(100)) if_c();

  assign if_a.tile_map  = map_v;
  assign if_b.tile_map  = map_v[239:0];
  assign if_c.tile_map  = map_v;
  assign if_a.game_over = go_v;
  assign if_b.game_over = go_v;
  assign if_c.game_over = go_v;

  vga_tile_renderer #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .GRID_COLS(10), .GRID_ROWS(10), .TILE_W(4), .TILE_H(3)
  ) dut_a (.pixel_clk(clk), .rst(rst), .bus(if_a));

  vga_tile_renderer #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .GRID_COLS(8), .GRID_ROWS(10), .TILE_W(4), .TILE_H(3)
  ) dut_b (.pixel_clk(clk), .rst(rst), .bus(if_b));

  vga_tile_renderer dut_c (.pixel_clk(clk), .rst(rst), .bus(if_c));

  // {rgb[7:0], hsync, vsync, frame_start}
  logic [10:0] obs [3];
  assign obs[0] = {if_a.red, if_a.green, if_a.blue, if_a.hsync, if_a.vsync, if_a.frame_start};
  assign obs[1] = {if_b.red, if_b.green, if_b.blue, if_b.hsync, if_b.vsync, if_b.frame_start};
  assign obs[2] = {if_c.red, if_c.green, if_c.blue, if_c.hsync, if_c.vsync, if_c.frame_start};

  int P_HA [3] = '{40, 40, 640};
  int P_HF [3] = '{4, 4, 16};
  int P_HS [3] = '{6, 6, 96};
  int P_HB [3] = '{6, 6, 48};
  int P_VA [3] = '{30, 30, 480};
  int P_VF [3] = '{2, 2, 10};
  int P_VS [3] = '{2, 2, 2};
  int P_VB [3] = '{3, 3, 29};
  int P_TW [3] = '{4, 4, 64};
  int P_TH [3] = '{3, 3, 48};
  int P_COLS [3] = '{10, 8, 10};
  int P_ROWS [3] = '{10, 10, 10};
  logic [7:0] PAL [8] = '{8'hFF, 8'h6D, 8'hE0, 8'h03, 8'h00, 8'h80, 8'hF8, 8'hE3};

  localparam logic [10:0] RST_OUT = 11'h006;
  localparam logic [10:0] M_RGB = 11'h7F8;
  localparam logic [10:0] M_HS  = 11'h004;
  localparam logic [10:0] M_FS  = 11'h001;

  logic [10:0]  p1 [3];
  logic [10:0]  p2 [3];
  logic [299:0] smap [3];
  logic [1:0]   sgo [3];
  int k = 0;
  int checks = 0;
  int errors = 0;

  function automatic int htot(int i);
    return P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
  endfunction
  function automatic int vtot(int i);
    return P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
  endfunction

  // Expected pins for raster position (hc, vc) using the model's current snapshot.
  function automatic logic [10:0] model(int i, int hc, int vc);
    logic [7:0] rgb;
    logic hs, vs, fs;
    int tx, ty;
    logic [2:0] code;
    rgb = 8'h00;
    if (hc < P_HA[i] && vc < P_VA[i]) begin
      if (sgo[i] == 2'd1)      rgb = 8'hC0;
      else if (sgo[i] == 2'd2) rgb = 8'h03;
      else if (sgo[i] == 2'd3) rgb = 8'h49;
      else begin
        tx = hc / P_TW[i];
        ty = vc / P_TH[i];
        if (tx < P_COLS[i] && ty < P_ROWS[i]) begin
          code = smap[i][3*(ty*P_COLS[i]+tx) +: 3];
          rgb = PAL[code];
        end
      end
    end
    hs = !(hc >= P_HA[i]+P_HF[i] && hc < P_HA[i]+P_HF[i]+P_HS[i]);
    vs = !(vc >= P_VA[i]+P_VF[i] && vc < P_VA[i]+P_VF[i]+P_VS[i]);
    fs = (hc == 0 && vc == 0);
    return {rgb, hs, vs, fs};
  endfunction

  task automatic chk(string tag, logic [10:0] o, logic [10:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  // One clock: advance model (2-cycle latency), then compare all instances.
  task automatic step();
    logic [10:0] e [3];
    bit sn [3];
    int hc, vc;
    for (int i = 0; i < 3; i++) begin
      hc = k % htot(i);
      vc = (k / htot(i)) % vtot(i);
      e[i]  = model(i, hc, vc);
      sn[i] = (hc == 0 && vc == P_VA[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        p1[i] = RST_OUT; p2[i] = RST_OUT; smap[i] = '0; sgo[i] = 2'd0;
      end else begin
        p2[i] = p1[i];
        p1[i] = e[i];
        if (sn[i]) begin smap[i] = map_v; sgo[i] = go_v; end
      end
    end
    if (rst) k = 0; else k++;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("inst%0d k=%0d", i, k), obs[i], p2[i]);
  endtask

  // Step until the pins show raster position pos (cycles since reset release).
  task automatic run_to(int pos);
    int n = 0;
    while (k - 2 != pos && n < 30000) begin
      step();
      n++;
    end
    checks++;
    assert (k - 2 == pos) else begin
      errors++;
      $error("FAIL run_to observed=%0d expected=%0d", k - 2, pos);
    end
  endtask

  task automatic spot(string tag, int i, int pos, logic [10:0] mask, logic [10:0] x);
    run_to(pos);
    chk(tag, obs[i] & mask, x);
  endtask

  task automatic set_cell(int r, int c, logic [2:0] code);
    map_v[3*(r*10+c) +: 3] = code;
  endtask

  localparam int FR = 56 * 37;

  initial begin
    rst = 1'b1; map_v = '0; go_v = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    rst = 1'b1;                 // mid-line reset
    repeat (5) step();
    for (int c = 0; c < 100; c++)
      map_v[3*c +: 3] = (c >= 30) ? 3'($urandom_range(0, 7)) : 3'd0;
    set_cell(0, 0, 3'd2);
    set_cell(0, 1, 3'd3);
    set_cell(2, 2, 3'd7);
    set_cell(5, 5, 3'd0);
    rst = 1'b0;

    spot("first_frame_start", 0, 0, M_FS, 11'h001);
    spot("def_hsync_655", 2, 655, M_HS, 11'h004);
    spot("def_hsync_656", 2, 656, M_HS, 11'h000);

    spot("tile_px3_red", 0, FR + 3, M_RGB, {8'hE0, 3'b000});
    spot("tile_px4_blue", 0, FR + 4, M_RGB, {8'h03, 3'b000});
    spot("row1_white", 0, FR + 3*56, M_RGB, {8'hFF, 3'b000});
    spot("code7_magenta", 0, FR + 6*56 + 8, M_RGB, {8'hE3, 3'b000});
    run_to(FR + 12*56);
    set_cell(5, 5, 3'd6);       // mid-frame map change
    spot("snap_hold_white", 0, FR + 15*56 + 20, M_RGB, {8'hFF, 3'b000});
    spot("narrow_grid_black", 1, FR + 15*56 + 32, M_RGB, 11'h000);
    spot("snap_next_explode", 0, 2*FR + 15*56 + 20, M_RGB, {8'hF8, 3'b000});
    run_to(2*FR + 20*56);
    go_v = 2'd1;
    spot("banner_p1", 0, 3*FR, M_RGB, {8'hC0, 3'b000});
    spot("banner_hblank", 0, 3*FR + 44, M_RGB, 11'h000);
    run_to(3*FR + 20*56);
    go_v = 2'd3;
    spot("banner_vblank", 0, 3*FR + 31*56, M_RGB, 11'h000);
    spot("banner_draw", 0, 4*FR + 15*56 + 20, M_RGB, {8'h49, 3'b000});
    repeat (100) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
